// File: rtl/cmd_rsp.sv
// cmd_rsp: UART command receiver that buffers a command up to TERM and answers AOK/ERR on TX.
module uart_rx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);
  localparam int CW = $clog2(DIV);
  logic [1:0] sync;
  logic active;
  logic [CW-1:0] bcnt;
  logic [3:0] bit_n;
  logic [7:0] sh;
  // samples land mid-bit: half a bit after the start edge, then one bit apart
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      active <= 1'b0;
      bcnt <= '0;
      bit_n <= '0;
      sh <= '0;
      rx_data <= '0;
      rdy <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      if (clr_rdy) rdy <= 1'b0;
      if (!active) begin
        if (!sync[1]) begin
          active <= 1'b1;
          bcnt <= CW'(DIV / 2 - 1);
          bit_n <= '0;
        end
      end else if (bcnt != '0) bcnt <= bcnt - 1'b1;
      else begin
        bcnt <= CW'(DIV - 1);
        bit_n <= bit_n + 1'b1;
        if (bit_n == 4'd0 && sync[1]) active <= 1'b0;
        else if (bit_n == 4'd9) begin
          active <= 1'b0;
          if (sync[1]) begin
            rdy <= 1'b1;
            rx_data <= sh;
          end
        end else if (bit_n != 4'd0) sh <= {sync[1], sh[7:1]};
      end
    end
endmodule

module uart_tx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);
  localparam int CW = $clog2(DIV);
  logic [9:0] sh;
  logic active;
  logic [CW-1:0] bcnt;
  logic [3:0] bit_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '1;
      active <= 1'b0;
      bcnt <= '0;
      bit_n <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!active) begin
        if (trmt) begin
          sh <= {1'b1, tx_data, 1'b0};
          active <= 1'b1;
          bcnt <= CW'(DIV - 1);
          bit_n <= '0;
        end
      end else if (bcnt != '0) bcnt <= bcnt - 1'b1;
      else begin
        bcnt <= CW'(DIV - 1);
        sh <= {1'b1, sh[9:1]};
        bit_n <= bit_n + 1'b1;
        if (bit_n == 4'd9) begin
          active <= 1'b0;
          tx_done <= 1'b1;
        end
      end
    end
  assign tx = sh[0];
endmodule

module cmd_rsp #(
  parameter int BUF_DEPTH = 16,
  parameter logic [7:0] TERM = 8'h0D,
  parameter int BAUD_DIV = 16,
  localparam int LW = $clog2(BUF_DEPTH + 1),
  localparam int AW = $clog2(BUF_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  output logic          cmd_rdy,
  output logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy
);
  typedef enum logic [1:0] {COLLECT, LOAD, SEND, WAIT} state_t;
  state_t state, nxt;
  logic [7:0] rx_data, tx_data;
  logic rx_rdy, trmt, tx_done;
  logic [LW-1:0] cnt;
  logic ovf;
  logic [3:0] ridx;
  logic [7:0] mem [BUF_DEPTH];
  logic got, is_term, accept, full;
  assign got = state == COLLECT && rx_rdy;
  assign is_term = rx_data == TERM;
  assign accept = cnt != '0 && !ovf;
  assign full = cnt == LW'(BUF_DEPTH);
  uart_rx #(.DIV(BAUD_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(RX), .clr_rdy(rx_rdy), .rx_data(rx_data), .rdy(rx_rdy)
  );
  uart_tx #(.DIV(BAUD_DIV)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .tx(TX), .tx_done(tx_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      COLLECT: if (got && is_term) nxt = LOAD;
      LOAD: nxt = SEND;
      SEND: nxt = WAIT;
      WAIT: if (tx_done) nxt = (ridx == 4'd4 || ridx == 4'd9) ? COLLECT : LOAD;
      default: nxt = COLLECT;
    endcase
  end
  always_comb begin
    busy = state != COLLECT;
    trmt = state == SEND;
  end
  always_comb begin
    tx_data = 8'h0A;
    case (ridx)
      4'd0: tx_data = 8'h41;
      4'd1: tx_data = 8'h4F;
      4'd2: tx_data = 8'h4B;
      4'd5: tx_data = 8'h45;
      4'd6, 4'd7: tx_data = 8'h52;
      4'd3, 4'd8: tx_data = 8'h0D;
      default: tx_data = 8'h0A;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      ridx <= '0;
      cmd_len <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      cmd_rdy <= got && is_term && accept;
      if (got) begin
        if (is_term) begin
          cnt <= '0;
          ovf <= 1'b0;
          ridx <= accept ? 4'd0 : 4'd5;
          if (accept) cmd_len <= cnt;
        end else if (full) ovf <= 1'b1;
        else cnt <= cnt + 1'b1;
      end
      if (state == WAIT && tx_done) ridx <= ridx + 1'b1;
    end
  // buffer holds its contents across reset and between commands
  always_ff @(posedge clk)
    if (got && !is_term && !full) mem[cnt[AW-1:0]] <= rx_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: tb/tb_cmd_rsp.sv
// tb_cmd_rsp: scoreboard bench driving UART commands into cmd_rsp and decoding its TX responses.
`timescale 1ns/1ps
module tb_cmd_rsp;
  localparam int DIV = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX, cmd_rdy, busy;
  logic [4:0] cmd_len;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  int n_chk = 0, n_fail = 0, epoch = 0, model_len = 0;
  logic [7:0] exp_tx_q[$], exp_b_q[$], pend[$];
  int exp_len_q[$];
  bit povf = 1'b0;
  logic [7:0] aok [5] = '{8'h41, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
  logic [7:0] err [5] = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  cmd_rsp #(.BAUD_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd_rdy(cmd_rdy), .cmd_len(cmd_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference: a command is the bytes before TERM; accepted if 1..16 bytes arrived
  task automatic model_byte(input logic [7:0] b);
    if (b != 8'h0D) begin
      if (pend.size() < 16) pend.push_back(b);
      else povf = 1'b1;
    end else begin
      if (pend.size() != 0 && !povf) begin
        exp_len_q.push_back(pend.size());
        foreach (pend[i]) exp_b_q.push_back(pend[i]);
        foreach (aok[i]) exp_tx_q.push_back(aok[i]);
        model_len = pend.size();
      end else foreach (err[i]) exp_tx_q.push_back(err[i]);
      pend.delete();
      povf = 1'b0;
    end
  endtask

  task automatic send_uart(input logic [7:0] b);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (DIV) @(negedge clk);
    end
    RX = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] b);
    model_byte(b);
    send_uart(b);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk({name, "_len"}, 32'(cmd_len), 32'(model_len));
  endtask

  task automatic term(input string name);
    put(8'h0D);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_idle(name);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    epoch++;
    exp_tx_q.delete();
    pend.delete();
    povf = 1'b0;
    model_len = 0;
    repeat (3) @(negedge clk);
    chk({name, "_tx"}, 32'(TX), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
    chk({name, "_cmd_len"}, 32'(cmd_len), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin : tx_mon
    int ep;
    logic [7:0] b;
    logic ok;
    @(posedge rst_n);
    forever begin
      @(negedge TX);
      ep = epoch;
      repeat (DIV / 2) @(negedge clk);
      ok = TX == 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = TX;
      end
      repeat (DIV) @(negedge clk);
      ok = ok & TX;
      if (ep == epoch) begin
        if (exp_tx_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %02h, expected none", b);
        end else begin
          chk("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
          chk("tx_framing", 32'(ok), 32'd1);
        end
      end
    end
  end

  initial begin : cmd_mon
    int len;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_rdy === 1'b1) begin
        if (exp_len_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL cmd_unexpected: got cmd_rdy with cmd_len %0d, expected none", cmd_len);
        end else begin
          len = exp_len_q.pop_front();
          chk("cmd_len", 32'(cmd_len), 32'(len));
          @(negedge clk);
          chk("cmd_rdy_pulse", 32'(cmd_rdy), 32'd0);
          for (int i = 0; i < len; i++) begin
            rd_addr = 4'(i);
            #1;
            chk("rd_data", 32'(rd_data), 32'(exp_b_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    int n;
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_cmd_len", 32'(cmd_len), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    put(8'h41); put(8'h42); term("ab");
    term("empty");
    for (int i = 0; i < 17; i++) put(8'(8'h30 + i));
    term("ovf17");
    put(8'h58); term("x");
    for (int i = 0; i < 16; i++) put(8'(8'h60 + i));
    term("full16");
    put(8'h49);
    put(8'h0D);
    chk("inj_busy", 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    send_uart(8'h55);
    wait_idle("inj");
    put(8'h51); term("q");
    put(8'h52);
    put(8'h0D);
    chk("rsp_rst_busy", 32'(busy), 32'd1);
    repeat (DIV * 13) @(negedge clk);
    do_reset("mid_rsp_rst");
    put(8'h50); put(8'h51);
    do_reset("partial_rst");
    put(8'h5A); term("z");
    repeat (6) begin
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D) b = 8'h0E;
        put(b);
      end
      term("rnd");
    end
    repeat (20) @(negedge clk);
    chk("tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    chk("cmd_q_empty", 32'(exp_len_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
